// File: rtl/fifo_pi_responder.sv
// PI-side responder for the CPU<->MCU byte FIFO pair.
// Parses framed command packets and writes framed replies.
module fifo_pi_responder #(
    parameter int         STB_LEN = 4,
    parameter int         GAP     = 3,
    parameter int         TMO_W   = 20,
    parameter logic [7:0] VERSION = 8'h01
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_empty,
    input  logic [7:0]  rx_dat,
    output logic        rx_oe,
    input  logic        tx_empty,
    output logic [7:0]  tx_dat,
    output logic        tx_we,
    output logic        busy,
    output logic [15:0] pkt_cnt,
    output logic [7:0]  err_cnt
);
    typedef enum logic [1:0] {U_IDLE, U_SET, U_STB, U_GAP} unit_t;
    typedef enum logic [2:0] {
        SYNC, CMD, LEN, CMDPAY, WAITTX, HDR, BODY, DONE
    } st_t;

    unit_t            r_ust;
    logic [7:0]       r_ucnt;
    logic             r_urd;
    logic             r_rx_oe;
    logic             r_tx_we;
    logic [7:0]       r_tx_dat;
    logic [7:0]       r_rx_byte;
    st_t              r_st;
    st_t              w_nst;
    logic [7:0]       r_cmd;
    logic [7:0]       r_len;
    logic [7:0]       r_cnt;
    logic [1:0]       r_hidx;
    logic [1:0]       r_bidx;
    logic             r_echo_rd;
    logic [15:0]      r_sum;
    logic [15:0]      r_snap_pkt;
    logic [7:0]       r_snap_err;
    logic [TMO_W-1:0] r_tmo;
    logic [15:0]      r_pkt;
    logic [7:0]       r_err;

    logic       w_done;
    logic       w_uidle;
    logic       w_rd_req;
    logic       w_wr_req;
    logic [7:0] w_wr_byte;
    logic       w_echo;
    logic       w_timed;
    logic       w_tmo;
    logic [7:0] w_code;
    logic [7:0] w_rlen;
    logic [7:0] w_hdr_byte;
    logic [7:0] w_body_byte;
    logic [1:0] w_blast;

    assign w_done  = (r_ust == U_GAP) && (r_ucnt == 8'(GAP - 1));
    assign w_uidle = (r_ust == U_IDLE);
    assign w_echo  = (r_cmd == 8'h01);
    assign w_timed = (r_st == CMD) || (r_st == LEN) || (r_st == CMDPAY)
                   || ((r_st == BODY) && w_echo && r_echo_rd);
    assign w_tmo   = w_timed && w_uidle && (&r_tmo);

    assign rx_oe   = r_rx_oe;
    assign tx_we   = r_tx_we;
    assign tx_dat  = r_tx_dat;
    assign busy    = (r_st != SYNC);
    assign pkt_cnt = r_pkt;
    assign err_cnt = r_err;

    // Reply code, reply length and per-index header/body bytes
    always_comb begin
        w_code      = 8'hEE;
        w_rlen      = 8'h01;
        w_blast     = 2'd0;
        w_hdr_byte  = 8'h2B;
        w_body_byte = r_cmd;
        unique case (r_cmd)
            8'h01: begin w_code = 8'h81; w_rlen = r_len; end
            8'h02: begin w_code = 8'h82; w_rlen = 8'h04; w_blast = 2'd3; end
            8'h03: begin w_code = 8'h83; w_rlen = 8'h02; w_blast = 2'd1; end
            default: ;
        endcase
        if (r_hidx == 2'd1) w_hdr_byte = w_code;
        if (r_hidx == 2'd2) w_hdr_byte = w_rlen;
        if (r_cmd == 8'h03) begin
            w_body_byte = (r_bidx == 2'd0) ? r_sum[7:0] : r_sum[15:8];
        end else if (r_cmd == 8'h02) begin
            unique case (r_bidx)
                2'd0:    w_body_byte = r_snap_pkt[7:0];
                2'd1:    w_body_byte = r_snap_pkt[15:8];
                2'd2:    w_body_byte = r_snap_err;
                default: w_body_byte = VERSION;
            endcase
        end
    end

    // Strobe unit: one read or write handshake at a time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ust     <= U_IDLE;
            r_ucnt    <= 8'h00;
            r_urd     <= 1'b0;
            r_rx_oe   <= 1'b0;
            r_tx_we   <= 1'b0;
            r_tx_dat  <= 8'h00;
            r_rx_byte <= 8'h00;
        end else begin
            unique case (r_ust)
                U_IDLE: begin
                    if (w_wr_req) begin
                        r_tx_dat <= w_wr_byte;
                        r_urd    <= 1'b0;
                        r_ust    <= U_SET;
                    end else if (w_rd_req && !rx_empty) begin
                        r_rx_oe <= 1'b1;
                        r_urd   <= 1'b1;
                        r_ucnt  <= 8'h00;
                        r_ust   <= U_STB;
                    end
                end
                U_SET: begin
                    r_tx_we <= 1'b1;
                    r_ucnt  <= 8'h00;
                    r_ust   <= U_STB;
                end
                U_STB: begin
                    if (r_ucnt == 8'(STB_LEN - 1)) begin
                        r_rx_oe <= 1'b0;
                        r_tx_we <= 1'b0;
                        if (r_urd) r_rx_byte <= rx_dat;
                        r_ucnt  <= 8'h00;
                        r_ust   <= U_GAP;
                    end else begin
                        r_ucnt <= r_ucnt + 8'h01;
                    end
                end
                default: begin
                    if (w_done) r_ust  <= U_IDLE;
                    else        r_ucnt <= r_ucnt + 8'h01;
                end
            endcase
        end
    end

    // Packet FSM: next state and strobe requests
    always_comb begin
        w_nst     = r_st;
        w_rd_req  = 1'b0;
        w_wr_req  = 1'b0;
        w_wr_byte = 8'h00;
        unique case (r_st)
            SYNC: begin
                w_rd_req = 1'b1;
                if (w_done && r_rx_byte == 8'h2B) w_nst = CMD;
            end
            CMD: begin
                w_rd_req = 1'b1;
                if (w_done) w_nst = LEN;
            end
            LEN: begin
                w_rd_req = 1'b1;
                if (w_done)
                    w_nst = (w_echo || r_rx_byte == 8'h00) ? WAITTX : CMDPAY;
            end
            CMDPAY: begin
                w_rd_req = 1'b1;
                if (w_done && r_cnt == 8'h01) w_nst = WAITTX;
            end
            WAITTX: begin
                if (tx_empty) w_nst = HDR;
            end
            HDR: begin
                w_wr_req  = 1'b1;
                w_wr_byte = w_hdr_byte;
                if (w_done && r_hidx == 2'd2)
                    w_nst = (w_echo && r_len == 8'h00) ? DONE : BODY;
            end
            BODY: begin
                if (w_echo) begin
                    if (r_echo_rd) begin
                        w_rd_req = 1'b1;
                    end else begin
                        w_wr_req  = 1'b1;
                        w_wr_byte = r_rx_byte;
                        if (w_done && r_cnt == 8'h01) w_nst = DONE;
                    end
                end else begin
                    w_wr_req  = 1'b1;
                    w_wr_byte = w_body_byte;
                    if (w_done && r_bidx == w_blast) w_nst = DONE;
                end
            end
            default: w_nst = SYNC;
        endcase
        if (w_tmo) begin
            w_nst    = SYNC;
            w_rd_req = 1'b0;
        end
    end

    // Packet FSM: state, packet fields, timeout and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_st       <= SYNC;
            r_cmd      <= 8'h00;
            r_len      <= 8'h00;
            r_cnt      <= 8'h00;
            r_hidx     <= 2'd0;
            r_bidx     <= 2'd0;
            r_echo_rd  <= 1'b1;
            r_sum      <= 16'h0000;
            r_snap_pkt <= 16'h0000;
            r_snap_err <= 8'h00;
            r_tmo      <= '0;
            r_pkt      <= 16'h0000;
            r_err      <= 8'h00;
        end else begin
            r_st <= w_nst;
            if (!w_timed || w_done)
                r_tmo <= '0;
            else if (w_uidle && rx_empty && !(&r_tmo))
                r_tmo <= r_tmo + 1'b1;
            if (((r_st == SYNC) && w_done && r_rx_byte != 8'h2B) || w_tmo)
                if (r_err != 8'hFF) r_err <= r_err + 8'h01;
            if (r_st == DONE) r_pkt <= r_pkt + 16'h0001;
            unique case (r_st)
                CMD: begin
                    r_sum <= 16'h0000;
                    if (w_done) r_cmd <= r_rx_byte;
                end
                LEN: begin
                    if (w_done) begin
                        r_len <= r_rx_byte;
                        r_cnt <= r_rx_byte;
                    end
                end
                CMDPAY: begin
                    if (w_done) begin
                        r_cnt <= r_cnt - 8'h01;
                        if (r_cmd == 8'h03) r_sum <= r_sum + {8'h00, r_rx_byte};
                    end
                end
                WAITTX: begin
                    if (tx_empty) begin
                        r_hidx     <= 2'd0;
                        r_snap_pkt <= r_pkt;
                        r_snap_err <= r_err;
                    end
                end
                HDR: begin
                    if (w_done) begin
                        r_hidx    <= r_hidx + 2'd1;
                        r_bidx    <= 2'd0;
                        r_echo_rd <= 1'b1;
                    end
                end
                BODY: begin
                    if (w_done) begin
                        if (w_echo) begin
                            r_echo_rd <= ~r_echo_rd;
                            if (!r_echo_rd) r_cnt <= r_cnt - 8'h01;
                        end else begin
                            r_bidx <= r_bidx + 2'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fifo_pi_responder.sv
// Directed bench for fifo_pi_responder.
// Models both byte FIFOs and checks replies, strobes and counters.
module tb_fifo_pi_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_empty = 1'b1;
    logic [7:0]  rx_dat = 8'h00;
    logic        rx_oe;
    logic        tx_empty = 1'b1;
    logic [7:0]  tx_dat;
    logic        tx_we;
    logic        busy;
    logic [15:0] pkt_cnt;
    logic [7:0]  err_cnt;

    logic [7:0] rx_mem [0:255];
    logic [7:0] tx_mem [0:255];
    int rx_wp = 0;
    int rx_rp = 0;
    int tx_wp = 0;
    int n_chk = 0;
    int n_fail = 0;
    int stb_viol = 0;
    int empty_viol = 0;
    int ovl_viol = 0;
    int oe_len = 0;
    int we_len = 0;
    logic p_oe = 1'b0;
    logic p_we = 1'b0;

    always #5 clk = ~clk;

    fifo_pi_responder #(.STB_LEN(4), .GAP(3), .TMO_W(8), .VERSION(8'h01)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_empty(rx_empty), .rx_dat(rx_dat), .rx_oe(rx_oe),
        .tx_empty(tx_empty), .tx_dat(tx_dat), .tx_we(tx_we),
        .busy(busy), .pkt_cnt(pkt_cnt), .err_cnt(err_cnt)
    );

    // FIFO models: pointers advance on strobe fall
    always @(negedge clk) begin
        if (p_oe && !rx_oe) begin
            if (rst_n && oe_len != 4) stb_viol++;
            rx_rp++;
        end
        if (p_we && !tx_we) begin
            if (rst_n && we_len != 4) stb_viol++;
            tx_mem[tx_wp[7:0]] = tx_dat;
            tx_wp++;
        end
        oe_len = rx_oe ? oe_len + 1 : 0;
        we_len = tx_we ? we_len + 1 : 0;
        if (rx_oe && tx_we) ovl_viol++;
        if (rx_oe && rx_empty) empty_viol++;
        if (!rst_n) rx_rp = rx_wp;
        p_oe = rx_oe;
        p_we = tx_we;
        rx_empty = (rx_rp == rx_wp);
        rx_dat = rx_empty ? 8'h00 : rx_mem[rx_rp[7:0]];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] b);
        rx_mem[rx_wp[7:0]] = b;
        rx_wp++;
    endtask

    task automatic wait_idle(input string tag, input int max);
        int st;
        st = 0;
        for (int i = 0; i < max && st < 10; i++) begin
            @(posedge clk);
            #1;
            if (rx_rp == rx_wp && !busy && !rx_oe && !tx_we) st++;
            else st = 0;
        end
        chk({tag, "_idle"}, 32'(st >= 10), 32'd1);
    endtask

    task automatic expect_tx(input string tag, input int base,
                             input logic [7:0] e [8], input int n);
        chk({tag, "_len"}, 32'(tx_wp - base), 32'(n));
        for (int i = 0; i < n; i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(tx_mem[(base + i) % 256]),
                32'(e[i]));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        logic [7:0] e [8];
        int base;
        int hit;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_rx_oe", 32'(rx_oe), 0);
        chk("rst_tx_we", 32'(tx_we), 0);
        chk("rst_tx_dat", 32'(tx_dat), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_pkt", 32'(pkt_cnt), 0);
        chk("rst_err", 32'(err_cnt), 0);
        @(negedge clk);
        #2 rst_n = 1'b1;

        base = tx_wp;
        @(posedge clk);
        #2;
        push(8'h2B); push(8'h01); push(8'h03);
        push(8'hAA); push(8'hBB); push(8'hCC);
        wait_idle("t1", 2000);
        e = '{8'h2B, 8'h81, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'h00, 8'h00};
        expect_tx("t1", base, e, 6);
        chk("t1_pkt", 32'(pkt_cnt), 1);
        chk("t1_stb", 32'(stb_viol), 0);

        base = tx_wp;
        @(posedge clk);
        #2;
        push(8'h2B); push(8'h03); push(8'h02); push(8'hFF); push(8'h02);
        wait_idle("t2s", 2000);
        e = '{8'h2B, 8'h83, 8'h02, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00};
        expect_tx("t2s", base, e, 5);
        chk("t2s_pkt", 32'(pkt_cnt), 2);

        base = tx_wp;
        @(posedge clk);
        #2;
        push(8'h2B); push(8'h01); push(8'h00);
        wait_idle("t2e", 2000);
        e = '{8'h2B, 8'h81, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_tx("t2e", base, e, 3);
        chk("t2e_pkt", 32'(pkt_cnt), 3);

        base = tx_wp;
        @(posedge clk);
        #2;
        push(8'h55); push(8'h2B); push(8'h02); push(8'h00);
        wait_idle("t3", 2000);
        e = '{8'h2B, 8'h82, 8'h04, 8'h03, 8'h00, 8'h01, 8'h01, 8'h00};
        expect_tx("t3", base, e, 7);
        chk("t3_err", 32'(err_cnt), 1);
        chk("t3_pkt", 32'(pkt_cnt), 4);

        base = tx_wp;
        @(posedge clk);
        #2;
        push(8'h2B); push(8'h07); push(8'h01); push(8'h99);
        wait_idle("unk", 2000);
        e = '{8'h2B, 8'hEE, 8'h01, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_tx("unk", base, e, 4);
        chk("unk_pkt", 32'(pkt_cnt), 5);

        base = tx_wp;
        @(posedge clk);
        #2;
        push(8'h2B); push(8'h01); push(8'h05); push(8'h11);
        wait_idle("t4", 3000);
        e = '{8'h2B, 8'h81, 8'h05, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_tx("t4", base, e, 4);
        chk("t4_err", 32'(err_cnt), 2);
        chk("t4_busy", 32'(busy), 0);
        chk("t4_pkt", 32'(pkt_cnt), 5);

        tx_empty = 1'b0;
        base = tx_wp;
        @(posedge clk);
        #2;
        push(8'h2B); push(8'h01); push(8'h01); push(8'h5A);
        repeat (200) @(posedge clk);
        #1;
        chk("t5_hold_len", 32'(tx_wp - base), 0);
        chk("t5_hold_busy", 32'(busy), 1);
        chk("t5_hold_we", 32'(tx_we), 0);
        tx_empty = 1'b1;
        wait_idle("t5", 2000);
        e = '{8'h2B, 8'h81, 8'h01, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
        expect_tx("t5", base, e, 4);
        chk("t5_pkt", 32'(pkt_cnt), 6);
        chk("t5_empty_rd", 32'(empty_viol), 0);
        chk("t5_overlap", 32'(ovl_viol), 0);

        base = tx_wp;
        @(posedge clk);
        #2;
        push(8'h2B); push(8'h01); push(8'h03);
        push(8'h10); push(8'h20); push(8'h30);
        hit = 0;
        for (int i = 0; i < 1000 && hit == 0; i++) begin
            @(posedge clk);
            #1;
            if (tx_wp - base >= 3 && tx_we) hit = 1;
        end
        chk("t6_found_stb", 32'(hit), 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_tx_we", 32'(tx_we), 0);
        chk("t6_rx_oe", 32'(rx_oe), 0);
        chk("t6_tx_dat", 32'(tx_dat), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_pkt", 32'(pkt_cnt), 0);
        chk("t6_err", 32'(err_cnt), 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        base = tx_wp;
        @(posedge clk);
        #2;
        push(8'h2B); push(8'h02); push(8'h00);
        wait_idle("t6r", 2000);
        e = '{8'h2B, 8'h82, 8'h04, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00};
        expect_tx("t6r", base, e, 7);
        chk("t6r_pkt", 32'(pkt_cnt), 1);
        chk("end_stb", 32'(stb_viol), 0);
        chk("end_empty_rd", 32'(empty_viol), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
